metrics_counter_bank: RTL and testbench
=======================================

Name: metrics_counter_bank

Overview:
Multi-channel successor to the single 64-bit metrics counter in the SoC control-register path. It provides NUM_CH independent counters, each with its own enable, clear and count mode (cycles, event-level, event-edge), plus selectable wrap or saturate on overflow. Sticky overflow flags and a coherent all-channel snapshot let software read every counter as of the same clock edge. It sits beside the control registers: control bytes drive en/clear/mode/snapshot, and cnt/snap/ovf feed the register load inputs.

Parameters:
NUM_CH, 4, number of independent counter channels (1..16)
COUNTER_WIDTH, 64, bits per counter (8..64)
SATURATE, 0, 0 = wrap to zero on overflow; 1 = hold at all-ones

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
en  input  NUM_CH  per-channel count enable, level
clear  input  NUM_CH  per-channel synchronous clear, level; clears counter and ovf
mode  input  2*NUM_CH  per-channel mode, channel i at [2i+1:2i]
evt  input  NUM_CH  per-channel event input, synchronous to clk
snapshot  input  1  single-cycle request to capture all counters
cnt  output  NUM_CH*COUNTER_WIDTH  live counter values, channel i at [i*W +: W]
snap  output  NUM_CH*COUNTER_WIDTH  captured counter values, same packing
snap_valid  output  1  one-cycle pulse when snap is updated
ovf  output  NUM_CH  sticky overflow flag per channel

Behaviour:
- Reset when rst=1 at a clock edge: cnt=0, snap=0, snap_valid=0, ovf=0, evt_prev=0. Reset has priority over every other input and may arrive at any time, including during counting.
- Per-channel increment term inc_i, evaluated only when en[i]=1:
  - mode 00: cycle mode, inc=1 every cycle.
  - mode 01: level mode, inc=evt[i].
  - mode 10: edge mode, inc=evt[i] & ~evt_prev[i].
  - mode 11: reserved, inc=0 and the counter holds.
- evt_prev[i] is registered from evt[i] every cycle, regardless of en or mode. Switching into edge mode therefore never creates a spurious edge.
- Update priority per channel at each edge: rst > clear[i] > increment.
  - clear[i]=1: cnt_i<=0 and ovf[i]<=0, even if inc_i=1 in the same cycle.
  - Otherwise, if inc_i=1 and cnt_i != all-ones: cnt_i<=cnt_i+1.
  - Otherwise, if inc_i=1 and cnt_i == all-ones: ovf[i]<=1. cnt_i<=0 when SATURATE=0; cnt_i holds all-ones when SATURATE=1. This is the overflow event, and it sets ovf under both settings.
- Latency: an increment qualified in cycle N is visible on cnt at N+1. All arithmetic is unsigned COUNTER_WIDTH-bit with no carry out.
- ovf is sticky. Only clear[i] or rst deasserts it.
- Snapshot: when snapshot=1 at edge N, snap<=cnt as registered before edge N, for all channels simultaneously. snap_valid=1 for the cycle after edge N only.
  - Simultaneous clear[i] or increment does not affect the captured value; it is the pre-update value.
  - Back-to-back snapshot pulses capture on every cycle, and snap_valid stays high for consecutive cycles.
  - snap holds its value between snapshots; clear does not affect snap.
- Channels are fully independent; no cross-channel arbitration.
- Output cnt, snap and ovf are direct register outputs with no combinational path from inputs.

Test Plan:
- Reset/cycle mode (W=8, NUM_CH=4): rst for 2 cycles, then en=4'b0001, mode0=00 for 10 cycles -> cnt0=10, cnt1..3=0, ovf=0, snap=0, snap_valid never high.
- Edge vs level (W=8): ch1 mode=10, ch2 mode=01, both enabled, evt held high for 5 cycles then low 3 cycles, repeated 3 times -> cnt1=3, cnt2=15. evt already high when ch1 switches into edge mode -> no count.
- Wrap and saturate (W=8, cycle mode): preload by counting 255 cycles, then 2 more.
  - SATURATE=0 -> cnt=1, ovf=1.
  - SATURATE=1 -> cnt=255, ovf=1.
  - Further counting leaves ovf=1 until clear.
- Clear priority: cnt0=42, clear0=1 and en0=1 in the same cycle with ovf0=1 -> next cycle cnt0=0, ovf0=0. Clear held 3 cycles -> cnt0 stays 0.
- Coherent snapshot: ch0..3 counting in cycle mode from different starts (0, 10, 20, 30). Pulse snapshot at cycle when cnt=(7,17,27,37), with clear2=1 the same cycle -> next cycle snap=(7,17,27,37), snap_valid=1 for one cycle, cnt2=0.
- Reset mid-operation: all channels counting with ovf3=1; assert rst one cycle together with snapshot -> next cycle all cnt, snap, ovf=0, snap_valid=0. Counting resumes from 0 when rst drops.

Source files
------------

// File: rtl/metrics_counter_bank.sv
// Multi-channel metrics counter bank: per-channel enable/clear/mode counters
// with wrap or saturate overflow, sticky overflow flags and a coherent
// all-channel snapshot register.
module metrics_counter_bank #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned COUNTER_WIDTH = 64,
  parameter bit          SATURATE      = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CH-1:0]               en,
  input  logic [NUM_CH-1:0]               clear,
  input  logic [2*NUM_CH-1:0]             mode,
  input  logic [NUM_CH-1:0]               evt,
  input  logic                            snapshot,
  output logic [NUM_CH*COUNTER_WIDTH-1:0] cnt,
  output logic [NUM_CH*COUNTER_WIDTH-1:0] snap,
  output logic                            snap_valid,
  output logic [NUM_CH-1:0]               ovf
);

  localparam int unsigned W        = COUNTER_WIDTH;
  localparam int unsigned BANK_W   = NUM_CH * W;
  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  localparam logic [1:0] MODE_CYCLE = 2'b00;
  localparam logic [1:0] MODE_LEVEL = 2'b01;
  localparam logic [1:0] MODE_EDGE  = 2'b10;

  logic [BANK_W-1:0] cnt_q;
  logic [BANK_W-1:0] cnt_d;
  logic [BANK_W-1:0] snap_q;
  logic              snap_valid_q;
  logic [NUM_CH-1:0] ovf_q;
  logic [NUM_CH-1:0] ovf_d;
  logic [NUM_CH-1:0] evt_prev_q;
  logic [NUM_CH-1:0] inc_c;

  // Per-channel increment qualification and clear/increment/overflow update
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    inc_c = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (en[i]) begin
        case (mode[2*i +: 2])
          MODE_CYCLE: inc_c[i] = 1'b1;
          MODE_LEVEL: inc_c[i] = evt[i];
          MODE_EDGE:  inc_c[i] = evt[i] & ~evt_prev_q[i];
          default:    inc_c[i] = 1'b0;
        endcase
      end
      if (clear[i]) begin
        cnt_d[i*W +: W] = '0;
        ovf_d[i]        = 1'b0;
      end else if (inc_c[i]) begin
        if (cnt_q[i*W +: W] != CNT_MAX) begin
          cnt_d[i*W +: W] = cnt_q[i*W +: W] + W'(1);
        end else begin
          ovf_d[i]        = 1'b1;
          cnt_d[i*W +: W] = SATURATE ? CNT_MAX : '0;
        end
      end
    end
  end

  // Counter, flag, event history and snapshot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      ovf_q        <= '0;
      evt_prev_q   <= '0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      evt_prev_q   <= evt;
      snap_valid_q <= snapshot;
      // Capture pre-update values so every channel reflects the same edge
      if (snapshot) begin
        snap_q <= cnt_q;
      end
    end
  end

  assign cnt        = cnt_q;
  assign snap       = snap_q;
  assign snap_valid = snap_valid_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_metrics_counter_bank.sv
// Scoreboard bench for metrics_counter_bank: one wrapping and one saturating
// instance share stimulus; expectations are queued as stimulus is applied and
// checked once the outputs have settled.
module tb_metrics_counter_bank;

  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 8;

  logic           clk;
  logic           rst;
  logic [NCH-1:0] en;
  logic [NCH-1:0] clear;
  logic [2*NCH-1:0] mode;
  logic [NCH-1:0] evt;
  logic           snapshot;

  logic [NCH*W-1:0] cnt_a, snap_a, cnt_s, snap_s;
  logic             sv_a, sv_s;
  logic [NCH-1:0]   ovf_a, ovf_s;

  metrics_counter_bank #(.NUM_CH(NCH), .COUNTER_WIDTH(W), .SATURATE(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .mode(mode), .evt(evt),
    .snapshot(snapshot), .cnt(cnt_a), .snap(snap_a), .snap_valid(sv_a), .ovf(ovf_a)
  );

  metrics_counter_bank #(.NUM_CH(NCH), .COUNTER_WIDTH(W), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .mode(mode), .evt(evt),
    .snapshot(snapshot), .cnt(cnt_s), .snap(snap_s), .snap_valid(sv_s), .ovf(ovf_s)
  );

  localparam int SEL_CNT   = 0;
  localparam int SEL_SNAP  = 1;
  localparam int SEL_OVF   = 2;
  localparam int SEL_SV    = 3;
  localparam int SEL_CNT_S = 4;
  localparam int SEL_OVF_S = 5;
  localparam int SEL_SVCNT = 6;

  typedef struct {
    string tag;
    int    sel;
    int    ch;
    int    exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   sv_pulses = 0;
  int   sv_base = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running count of snap_valid pulses on the wrapping instance
  always @(posedge clk) sv_pulses <= sv_pulses + int'(sv_a);

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int observe(input int sel, input int ch);
    case (sel)
      SEL_CNT:   return int'(cnt_a[ch*W +: W]);
      SEL_SNAP:  return int'(snap_a[ch*W +: W]);
      SEL_OVF:   return int'(ovf_a[ch]);
      SEL_SV:    return int'(sv_a);
      SEL_CNT_S: return int'(cnt_s[ch*W +: W]);
      SEL_OVF_S: return int'(ovf_s[ch]);
      SEL_SVCNT: return sv_pulses - sv_base;
      default:   return -1;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input int ch, input int exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.ch = ch; e.exp = exp;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s[%0d]", e.tag, e.ch), observe(e.sel, e.ch), e.exp);
    end
  endtask

  // One rising edge; returns at the following falling edge with outputs settled
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = '0; clear = '0; mode = '0; evt = '0; snapshot = 1'b0;
    @(negedge clk);

    // Reset state
    tick(2);
    for (int c = 0; c < 4; c++) begin
      push("rst_cnt", SEL_CNT, c, 0);
      push("rst_snap", SEL_SNAP, c, 0);
      push("rst_ovf", SEL_OVF, c, 0);
    end
    push("rst_sv", SEL_SV, 0, 0);
    drain();

    // Cycle mode on channel 0 only
    rst = 1'b0;
    sv_base = sv_pulses;
    en = 4'b0001; mode = '0;
    push("cyc_cnt", SEL_CNT, 0, 10);
    push("cyc_cnt", SEL_CNT, 1, 0);
    push("cyc_cnt", SEL_CNT, 2, 0);
    push("cyc_cnt", SEL_CNT, 3, 0);
    push("cyc_ovf", SEL_OVF, 0, 0);
    push("cyc_snap", SEL_SNAP, 0, 0);
    push("cyc_svcnt", SEL_SVCNT, 0, 0);
    tick(10);
    drain();
    en = '0;

    // Edge (ch1) vs level (ch2)
    do_reset();
    mode = 8'b00_01_10_00;
    en = 4'b0110;
    for (int r = 0; r < 3; r++) begin
      evt = 4'b0110; tick(5);
      evt = 4'b0000; tick(3);
    end
    push("edge_cnt", SEL_CNT, 1, 3);
    push("level_cnt", SEL_CNT, 2, 15);
    drain();
    // Reserved mode holds; entering edge mode with evt already high adds nothing
    mode = 8'b00_01_11_00; evt = 4'b0010; tick(2);
    push("rsvd_cnt", SEL_CNT, 1, 3);
    drain();
    mode = 8'b00_01_10_00; tick(3);
    push("edge_switch_cnt", SEL_CNT, 1, 3);
    push("level_hold_cnt", SEL_CNT, 2, 15);
    drain();
    evt = 4'b0000; tick(1);
    evt = 4'b0010; tick(1);
    push("edge_new_cnt", SEL_CNT, 1, 4);
    drain();
    evt = '0; en = '0;

    // Wrap vs saturate on channel 0
    do_reset();
    mode = '0; en = 4'b0001;
    tick(255);
    push("pre_wrap_cnt", SEL_CNT, 0, 255);
    push("pre_wrap_ovf", SEL_OVF, 0, 0);
    push("pre_sat_cnt", SEL_CNT_S, 0, 255);
    drain();
    tick(2);
    push("wrap_cnt", SEL_CNT, 0, 1);
    push("wrap_ovf", SEL_OVF, 0, 1);
    push("sat_cnt", SEL_CNT_S, 0, 255);
    push("sat_ovf", SEL_OVF_S, 0, 1);
    drain();
    tick(5);
    push("wrap_sticky_cnt", SEL_CNT, 0, 6);
    push("wrap_sticky_ovf", SEL_OVF, 0, 1);
    push("sat_sticky_cnt", SEL_CNT_S, 0, 255);
    push("sat_sticky_ovf", SEL_OVF_S, 0, 1);
    drain();

    // Clear beats increment and drops ovf
    tick(36);
    push("pre_clr_cnt", SEL_CNT, 0, 42);
    push("pre_clr_ovf", SEL_OVF, 0, 1);
    drain();
    clear = 4'b0001;
    tick(1);
    push("clr_cnt", SEL_CNT, 0, 0);
    push("clr_ovf", SEL_OVF, 0, 0);
    push("clr_sat_cnt", SEL_CNT_S, 0, 0);
    push("clr_sat_ovf", SEL_OVF_S, 0, 0);
    drain();
    tick(2);
    push("clr_hold_cnt", SEL_CNT, 0, 0);
    drain();
    clear = '0;
    tick(1);
    push("post_clr_cnt", SEL_CNT, 0, 1);
    drain();
    en = '0;

    // Coherent snapshot with simultaneous clear on channel 2
    do_reset();
    mode = '0;
    en = 4'b1000; tick(10);
    en = 4'b1100; tick(10);
    en = 4'b1110; tick(10);
    en = 4'b1111; tick(7);
    push("pre_snap_cnt", SEL_CNT, 0, 7);
    push("pre_snap_cnt", SEL_CNT, 3, 37);
    push("pre_snap_sv", SEL_SV, 0, 0);
    drain();
    snapshot = 1'b1; clear = 4'b0100;
    tick(1);
    push("snap_val", SEL_SNAP, 0, 7);
    push("snap_val", SEL_SNAP, 1, 17);
    push("snap_val", SEL_SNAP, 2, 27);
    push("snap_val", SEL_SNAP, 3, 37);
    push("snap_sv", SEL_SV, 0, 1);
    push("snap_clr_cnt", SEL_CNT, 2, 0);
    push("snap_live_cnt", SEL_CNT, 0, 8);
    drain();
    snapshot = 1'b0; clear = '0;
    tick(1);
    push("snap_sv_drop", SEL_SV, 0, 0);
    push("snap_hold", SEL_SNAP, 2, 27);
    push("snap_post_cnt", SEL_CNT, 2, 1);
    drain();
    // Back-to-back snapshots (cnt0 is 9 here)
    snapshot = 1'b1;
    tick(1);
    push("b2b_snap1", SEL_SNAP, 0, 9);
    push("b2b_sv1", SEL_SV, 0, 1);
    drain();
    tick(1);
    push("b2b_snap2", SEL_SNAP, 0, 10);
    push("b2b_sv2", SEL_SV, 0, 1);
    drain();
    snapshot = 1'b0;
    tick(1);
    push("b2b_sv_end", SEL_SV, 0, 0);
    push("b2b_hold", SEL_SNAP, 0, 10);
    drain();

    // Reset mid-operation together with a snapshot request
    tick(256);
    push("pre_rst_ovf", SEL_OVF, 3, 1);
    drain();
    rst = 1'b1; snapshot = 1'b1;
    tick(1);
    for (int c = 0; c < 4; c++) begin
      push("mid_rst_cnt", SEL_CNT, c, 0);
      push("mid_rst_snap", SEL_SNAP, c, 0);
      push("mid_rst_ovf", SEL_OVF, c, 0);
    end
    push("mid_rst_sv", SEL_SV, 0, 0);
    drain();
    rst = 1'b0; snapshot = 1'b0;
    tick(1);
    for (int c = 0; c < 4; c++) push("resume_cnt", SEL_CNT, c, 1);
    push("resume_sv", SEL_SV, 0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
